// File: rtl/ioctl_loader_if.sv
// HPS ioctl download stream in, dn_* memory load bus and status out.
// master = emu top/system side, slave = ioctl_loader.
interface ioctl_loader_if #(
  parameter int AW = 17
);
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic [7:0]    ioctl_index;
  logic          ioctl_wait;
  logic          dn_ce;
  logic [AW-1:0] dn_addr;
  logic [7:0]    dn_data;
  logic [7:0]    dn_index;
  logic          dn_wr;
  logic          dn_busy;
  logic          overflow;
  logic [24:0]   byte_count;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, dn_ce,
    input  ioctl_wait, dn_addr, dn_data, dn_index, dn_wr, dn_busy, overflow, byte_count
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, dn_ce,
    output ioctl_wait, dn_addr, dn_data, dn_index, dn_wr, dn_busy, overflow, byte_count
  );
endinterface

// File: rtl/ioctl_loader.sv
// Buffers ioctl download bytes in a FIFO and replays them as dn_wr pulses paced by dn_ce.
// Latency: byte sampled at edge t -> dn_wr high in the cycle after edge t+1 (empty FIFO, dn_ce high).
// Backpressure: ioctl_wait at HI_WM occupancy; bytes arriving while full are dropped and flagged.
module ioctl_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 17,
  parameter int HI_WM = 12,
  parameter int HOLD  = 8
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  ioctl_loader_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = AW + 16;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [25:0] ADDR_LIM = 26'(1) << AW;
  localparam logic [PW:0] WM = (PW+1)'(HI_WM);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [EW-1:0] mem [DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr;
  logic [PW:0]   occ, occ_nxt;
  logic [EW-1:0] rd_entry;
  logic          full, empty, in_range, push_req, push, pop, drop;
  logic          dl_q, dl_rise;
  logic [1:0]    state, state_nxt;
  logic [HW-1:0] hold_cnt;

  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign in_range = ({1'b0, bus.ioctl_addr} < ADDR_LIM);
  assign push_req = bus.ioctl_download && bus.ioctl_wr && in_range;
  assign pop      = bus.dn_ce && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign dl_rise  = bus.ioctl_download && !dl_q;
  assign occ      = wr_ptr - rd_ptr;
  assign occ_nxt  = occ + (PW+1)'(push) - (PW+1)'(pop);
  assign rd_entry = mem[rd_ptr[PW-1:0]];
  assign bus.dn_busy = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (dl_rise) state_nxt = S_LOAD;
      S_LOAD:  if (!bus.ioctl_download) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (dl_rise)
          state_nxt = S_LOAD;
        else if (empty && !bus.dn_wr)
          state_nxt = (HOLD == 1) ? S_IDLE : S_HOLD;
      end
      default: begin
        if (dl_rise)
          state_nxt = S_LOAD;
        else if (hold_cnt <= HW'(1))
          state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (push)
      mem[wr_ptr[PW-1:0]] <= {bus.ioctl_addr[AW-1:0], bus.ioctl_dout, bus.ioctl_index};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      dl_q           <= 1'b0;
      state          <= S_IDLE;
      hold_cnt       <= '0;
      bus.ioctl_wait <= 1'b0;
      bus.dn_addr    <= '0;
      bus.dn_data    <= '0;
      bus.dn_index   <= '0;
      bus.dn_wr      <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.byte_count <= '0;
    end else begin
      dl_q  <= bus.ioctl_download;
      state <= state_nxt;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        bus.dn_addr  <= rd_entry[EW-1:16];
        bus.dn_data  <= rd_entry[15:8];
        bus.dn_index <= rd_entry[7:0];
      end
      bus.dn_wr      <= pop;
      bus.ioctl_wait <= (state_nxt != S_IDLE) && (occ_nxt >= WM);
      // A drop on the start cycle belongs to the new download, so set wins.
      bus.overflow   <= (bus.overflow && !dl_rise) || drop;
      if (dl_rise)
        bus.byte_count <= '0;
      else if (bus.dn_wr)
        bus.byte_count <= bus.byte_count + 25'd1;
      if (state == S_DRAIN && state_nxt == S_HOLD)
        hold_cnt <= HW'(HOLD - 1);
      else if (state == S_HOLD)
        hold_cnt <= hold_cnt - HW'(1);
    end
  end
endmodule

// File: doc/ioctl_loader.md
Name: ioctl_loader

Overview:
Buffers the HPS ioctl download byte stream and replays it onto the system's dn_* ROM/RAM load bus, pacing writes to a drain strobe. The target memories accept at most one write per dn_ce. Throttles the HPS with ioctl_wait and produces dn_busy, which holds the system in reset until every byte has landed plus a settle holdoff. Sits between the emu top-level ioctl inputs and the system block's dn_addr/dn_data/dn_wr/dn_index inputs.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 4
AW, 17, width of dn_addr; bytes whose ioctl_addr is at or above 2^AW are discarded
HI_WM, 12, occupancy at or above which ioctl_wait asserts; must be below DEPTH
HOLD, 8, clk_sys cycles dn_busy stays high after the last write; minimum 1

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ioctl_download  in  1  download window active
ioctl_wr  in  1  byte strobe, one cycle per byte
ioctl_addr  in  25  byte address
ioctl_dout  in  8  byte data
ioctl_index  in  8  download target index
ioctl_wait  out  1  HPS must stop issuing ioctl_wr
dn_ce  in  1  drain enable strobe; a pop is allowed only on cycles where it is high
dn_addr  out  AW  load address
dn_data  out  8  load data
dn_index  out  8  load index
dn_wr  out  1  single-cycle write pulse
dn_busy  out  1  load in progress; drives system reset
overflow  out  1  sticky flag: a byte was dropped because the FIFO was full
byte_count  out  25  bytes delivered on dn_wr since the last download start

Behaviour:
- One clock domain (clk_sys); reset is asynchronous and active-low.
- Reset values: all outputs 0, FIFO empty, FSM in IDLE.
- Push: occurs when ioctl_download, ioctl_wr and ioctl_addr < 2^AW are all true and the FIFO is not full.
  - Entry stored: {ioctl_addr[AW-1:0], ioctl_dout, ioctl_index}.
  - Push while full: byte dropped, overflow set.
  - Out-of-range address: byte dropped silently; overflow unaffected.
- Pop: occurs on any cycle with dn_ce high and the FIFO non-empty.
  - dn_addr, dn_data and dn_index are registered from the popped entry at that edge.
  - dn_wr is high for exactly the following cycle.
  - dn_addr/dn_data/dn_index hold their value until the next pop.
- Latency: with an empty FIFO and dn_ce held high, a byte sampled at edge t produces dn_wr high in the cycle after edge t+1.
- Simultaneous push and pop: occupancy unchanged, FIFO order preserved. A push into a full FIFO on a cycle that also pops is accepted.
- Pointers: log2(DEPTH) bits plus a wrap bit. Full = pointer bits equal and wrap bits differ. Empty = all bits equal.
- ioctl_wait: registered from next-state occupancy.
  - Asserts when occupancy >= HI_WM.
  - Deasserts when occupancy < HI_WM.
  - Forced 0 in IDLE.
- byte_count: increments by 1 per dn_wr. Width 25; wraps to 0 after 2^25-1.
- Download start (rising edge of ioctl_download): clears byte_count and overflow.
- FSM:
  - IDLE (dn_busy=0): rising ioctl_download -> LOAD.
  - LOAD (dn_busy=1): ioctl_download falls -> DRAIN.
  - DRAIN (dn_busy=1): FIFO empty and no dn_wr in the current cycle -> HOLD, hold counter loaded with HOLD-1. ioctl_download rises again -> LOAD, FIFO contents kept.
  - HOLD (dn_busy=1): counter decrements each cycle; -> IDLE when it reaches 0 and the decrement occurs. ioctl_download rises -> LOAD.
  - Net effect: dn_busy stays high for exactly HOLD cycles after the cycle in which the final dn_wr is high.
- Reset mid-load: FIFO flushed immediately, dn_wr 0, overflow cleared, FSM -> IDLE. Bytes in flight are lost; the HPS must restart the download.
- dn_ce held low: FIFO fills, ioctl_wait asserts, no pops occur, and dn_busy stays high indefinitely.

Test Plan:
- Basic load: reset, then 4 bytes at addr 0..3 with data A0..A3, index 0x01, dn_ce=1. Expect 4 dn_wr pulses in order, each dn_addr/dn_data matching, dn_index 0x01, byte_count=4, dn_busy falling exactly 8 cycles after the 4th dn_wr.
- Backpressure: dn_ce=0, 12 consecutive writes. Expect ioctl_wait=1 after the 12th; set dn_ce=1 and ioctl_wait drops after 1 pop (occupancy 11); all 12 bytes delivered, overflow=0.
- Overflow: dn_ce=0, 17 writes ignoring ioctl_wait. Expect overflow=1, exactly 16 bytes delivered once dn_ce=1, byte_count=16. Then a new download rising edge clears overflow and byte_count.
- Range filter: write addr 0x1FFFF and 0x20000. Expect one dn_wr (addr 0x1FFFF); overflow=0.
- Simultaneous push/pop with dn_ce toggling every other cycle over 64 bytes: exact order and data preserved; occupancy never exceeds 2 when writes arrive every 2 cycles.
- Async reset asserted mid-load with 5 bytes queued: outputs go to 0 immediately; after release, no dn_wr occurs and dn_busy=0.
